cmt_stream_splitter: RTL
========================

CMT_STREAM_SPLITTER -- requirements
Module: cmt_stream_splitter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data beat width.
REQ-002 SHALL have parameter N_MAX, default 8: largest supported element size N.
REQ-003 SHALL have parameter FRAMES_MAX, default 16: largest frame count per run.
REQ-004 SHALL have port clk  in  1: sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1: one-cycle run request.
REQ-007 SHALL have port n_cfg  in  $clog2(N_MAX+1): element size N for the run.
REQ-008 SHALL have port frames_cfg  in  $clog2(FRAMES_MAX+1): frame count for the run.
REQ-009 SHALL have port reuse_kernel  in  1: when 1, kernel phase runs for frame 0 only.
REQ-010 SHALL have port data_in  in  WIDTH: input stream beat.
REQ-011 SHALL have port input_vld  in  1: data_in valid.
REQ-012 SHALL have port in_ready  out  1: beat accepted when input_vld && in_ready.
REQ-013 SHALL have port stall  in  1: downstream full.
REQ-014 SHALL have port kernel_out / kernel_vld  out  WIDTH / 1: kernel beat.
REQ-015 SHALL have port data_out / data_vld  out  WIDTH / 1: ternix beat.
REQ-016 SHALL have port kernel_last / data_last  out  1 / 1: final beat of phase.
REQ-017 SHALL have port busy, done, cfg_err  out  1 each: status.

Function
REQ-018 SHALL implement FSM IDLE, KERNEL, TERNIX, DONE.
REQ-019 IDLE: start with 1<=n_cfg<=N_MAX and 1<=frames_cfg<=FRAMES_MAX SHALL latch n_cfg, frames_cfg, reuse_kernel and go to KERNEL.
REQ-020 IDLE: start with illegal config SHALL stay IDLE and pulse cfg_err for one cycle.
REQ-021 in_ready SHALL equal !stall while in KERNEL or TERNIX, else 0.
REQ-022 Accepted beat in KERNEL SHALL appear on kernel_out with kernel_vld=1 exactly one cycle later; beat in TERNIX likewise on data_out/data_vld.
REQ-023 Output valids SHALL be single-cycle pulses; data buses SHALL be 0 when their valid is 0.
REQ-024 KERNEL SHALL accept exactly N*N beats, then go to TERNIX.
REQ-025 TERNIX SHALL accept exactly N*N*N beats, then increment frame counter.
REQ-026 After TERNIX, if frames remain: next state KERNEL when reuse_kernel=0, TERNIX when 1.
REQ-027 After final frame's TERNIX, SHALL go to DONE for one cycle (done=1), then IDLE.
REQ-028 done SHALL coincide with the output cycle of the last ternix beat's successor, i.e. one cycle after the last data_vld.
REQ-029 busy SHALL be 1 in KERNEL, TERNIX and DONE.
REQ-030 start while busy SHALL be ignored (no cfg_err, no restart).
REQ-031 Counters SHALL be sized for N_MAX*N_MAX and N_MAX**3 inclusive; no wrap within a run.
REQ-032 input_vld with in_ready=0 SHALL not advance any counter.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, clear all counters and latched config.
REQ-034 During reset all outputs SHALL be 0 (in_ready, valids, lasts, busy, done, cfg_err, buses).
REQ-035 Reset mid-run SHALL discard the run; first post-reset beat is not accepted until a new start.

Configuration
REQ-036 Macro CMT_SPLITTER_LAST_EN defined: kernel_last=1 with the N*N-th kernel beat of each kernel phase, data_last=1 with the N^3-th ternix beat of each frame.
REQ-037 Macro CMT_SPLITTER_LAST_EN undefined: kernel_last and data_last SHALL be tied 0; all other behaviour identical.

Verification
REQ-038 N=3, frames=1, continuous input_vld, 36 beats -> 9 kernel_vld then 27 data_vld pulses, each 1 cycle after accept, done one cycle after last data_vld.
REQ-039 N=2, frames=3, reuse_kernel=1, 28 beats -> 4 kernel beats then 24 ternix beats; kernel_last once, data_last 3 times (macro defined).
REQ-040 N=2, frames=2, reuse_kernel=0 -> sequence 4 kernel, 8 ternix, 4 kernel, 8 ternix; done once.
REQ-041 N=3, stall=1 for 5 cycles after beat 4 -> in_ready=0, no valids, counts held; stream resumes at beat 5 with correct routing.
REQ-042 start with n_cfg=0, then n_cfg=N_MAX+1 -> cfg_err pulses twice, busy stays 0.
REQ-043 rst_n low after 20 ternix beats of N=3 run -> all outputs 0 same cycle; new start with N=2 runs cleanly.

Source files
------------

// File: rtl/cmt_stream_splitter.sv
// Routes an input stream into N*N-beat kernel phases and N^3-beat ternix phases per frame.
// Optional kernel_last/data_last markers are enabled by defining CMT_SPLITTER_LAST_EN.
module cmt_stream_splitter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_MAX      = 8,
    parameter int unsigned FRAMES_MAX = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [$clog2(N_MAX+1)-1:0]        n_cfg,
    input  logic [$clog2(FRAMES_MAX+1)-1:0]   frames_cfg,
    input  logic                              reuse_kernel,
    input  logic [WIDTH-1:0]                  data_in,
    input  logic                              input_vld,
    output logic                              in_ready,
    input  logic                              stall,
    output logic [WIDTH-1:0]                  kernel_out,
    output logic                              kernel_vld,
    output logic [WIDTH-1:0]                  data_out,
    output logic                              data_vld,
    output logic                              kernel_last,
    output logic                              data_last,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err
);
    localparam int unsigned NW = $clog2(N_MAX + 1);
    localparam int unsigned FW = $clog2(FRAMES_MAX + 1);
    localparam int unsigned CW = $clog2(N_MAX * N_MAX * N_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_KERNEL, S_TERNIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, kmax_q, kmax_d, tmax_q, tmax_d;
    logic [FW-1:0]    frame_q, frame_d, frames_q, frames_d, frame_nx;
    logic             reuse_q, reuse_d, drain_q, drain_d, cfg_err_q, cfg_err_d;
    logic             kvld_q, kvld_d, dvld_q, dvld_d;
    logic [WIDTH-1:0] kout_q, kout_d, dout_q, dout_d;
    logic             klast_q, klast_d, dlast_q, dlast_d;
    logic             streaming, acc, legal, k_end, t_end;
    logic [CW-1:0]    n_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kmax_d    = kmax_q;
        tmax_d    = tmax_q;
        frame_d   = frame_q;
        frames_d  = frames_q;
        reuse_d   = reuse_q;
        drain_d   = drain_q;
        cfg_err_d = 1'b0;
        kvld_d    = 1'b0;
        kout_d    = '0;
        dvld_d    = 1'b0;
        dout_d    = '0;
        klast_d   = 1'b0;
        dlast_d   = 1'b0;

        streaming = (state_q == S_KERNEL) || (state_q == S_TERNIX);
        acc       = input_vld && streaming && !stall;
        n_ext     = CW'(n_cfg);
        legal     = (n_cfg != '0) && (n_cfg <= NW'(N_MAX)) &&
                    (frames_cfg != '0) && (frames_cfg <= FW'(FRAMES_MAX));
        k_end     = (cnt_q == kmax_q - CW'(1));
        t_end     = (cnt_q == tmax_q - CW'(1));
        frame_nx  = frame_q + FW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d  = S_KERNEL;
                        kmax_d   = n_ext * n_ext;
                        tmax_d   = n_ext * n_ext * n_ext;
                        frames_d = frames_cfg;
                        reuse_d  = reuse_kernel;
                        cnt_d    = '0;
                        frame_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_KERNEL: begin
                if (acc) begin
                    kvld_d  = 1'b1;
                    kout_d  = data_in;
                    klast_d = k_end;
                    if (k_end) begin
                        cnt_d   = '0;
                        state_d = S_TERNIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_TERNIX: begin
                if (acc) begin
                    dvld_d  = 1'b1;
                    dout_d  = data_in;
                    dlast_d = t_end;
                    if (t_end) begin
                        cnt_d   = '0;
                        frame_d = frame_nx;
                        if (frame_nx == frames_q) begin
                            state_d = S_DONE;
                            drain_d = 1'b0;
                        end else begin
                            state_d = reuse_q ? S_TERNIX : S_KERNEL;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                // First DONE cycle lets the last data beat drain; done asserts on the second.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_IDLE;
                    drain_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            kmax_q    <= '0;
            tmax_q    <= '0;
            frame_q   <= '0;
            frames_q  <= '0;
            reuse_q   <= 1'b0;
            drain_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            kvld_q    <= 1'b0;
            kout_q    <= '0;
            dvld_q    <= 1'b0;
            dout_q    <= '0;
            klast_q   <= 1'b0;
            dlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kmax_q    <= kmax_d;
            tmax_q    <= tmax_d;
            frame_q   <= frame_d;
            frames_q  <= frames_d;
            reuse_q   <= reuse_d;
            drain_q   <= drain_d;
            cfg_err_q <= cfg_err_d;
            kvld_q    <= kvld_d;
            kout_q    <= kout_d;
            dvld_q    <= dvld_d;
            dout_q    <= dout_d;
            klast_q   <= klast_d;
            dlast_q   <= dlast_d;
        end
    end

    assign in_ready   = streaming && !stall;
    assign kernel_out = kout_q;
    assign kernel_vld = kvld_q;
    assign data_out   = dout_q;
    assign data_vld   = dvld_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE) && drain_q;
    assign cfg_err    = cfg_err_q;
`ifdef CMT_SPLITTER_LAST_EN
    assign kernel_last = klast_q;
    assign data_last   = dlast_q;
`else
    assign kernel_last = 1'b0;
    assign data_last   = 1'b0;
    logic unused_last;
    assign unused_last = klast_q ^ dlast_q;
`endif

endmodule
